linebuf_3row_ctrl: RTL and testbench

Line-buffer controller for the 3×N vertical window. It accepts a raster pixel stream and drives two single-port line RAMs, which hold the previous two lines. For each input pixel it emits a registered 3-pixel column: top, middle and bottom rows at the same column. It sits directly upstream of the 3×3 window/filter stage and owns both line-RAM instances.

---
 rtl/linebuf_pkg.sv | 16 +
 rtl/linebuf_ram_sp.sv | 35 +++
 rtl/linebuf_3row_ctrl.sv | 164 ++++++++++++++++
 tb/tb_linebuf_3row_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/linebuf_pkg.sv
// Shared definitions for the 3-row line-buffer controller: FSM state
// encoding and the default geometry constants.
package linebuf_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_ADDR_WIDTH = 11;
  localparam int DEFAULT_LENGTH     = 1920;

  // RD: waiting for / capturing a pixel while the RAMs read column col.
  // WR: RAM read data is valid; write back the shifted lines and emit.
  typedef enum logic [0:0] {
    ST_RD = 1'b0,
    ST_WR = 1'b1
  } state_t;

endpackage

// File: rtl/linebuf_ram_sp.sv
// Single-port line RAM: synchronous active-high reset clears every word,
// one-cycle registered read, and the read register holds on write cycles.
module linebuf_ram_sp #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 11,
  parameter int DEPTH      = 1920
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] r_data
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] r_data_r;

  // Storage array plus read register; a write leaves the read data untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
      r_data_r <= {DATA_WIDTH{1'b0}};
    end else if (w_en) begin
      mem_r[addr] <= w_data;
    end else begin
      r_data_r <= mem_r[addr];
    end
  end

  assign r_data = r_data_r;

endmodule

// File: rtl/linebuf_3row_ctrl.sv
// Line-buffer controller for a 3xN vertical window. Accepts one raster pixel
// per two clocks and emits a registered column (line y-2, y-1, y) for it.
// Optional build macro: LINEBUF_PRIME_EN -- when defined, out_valid is held
// low until two complete lines have been absorbed.
module linebuf_3row_ctrl
  import linebuf_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int LENGTH     = DEFAULT_LENGTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_top,
  output logic [DATA_WIDTH-1:0] out_mid,
  output logic [DATA_WIDTH-1:0] out_bot,
  output logic [ADDR_WIDTH-1:0] out_col,
  output logic                  out_eol
);

  localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(LENGTH - 1);

  state_t                state_r;
  state_t                state_s;
  logic                  accept_s;
  logic                  w_en_s;
  logic                  last_col_s;
  logic                  emit_en_s;

  logic [DATA_WIDTH-1:0] pix_r;
  logic [ADDR_WIDTH-1:0] col_r;
  logic [1:0]            row_cnt_r;

  logic [DATA_WIDTH-1:0] ram0_rd_s;
  logic [DATA_WIDTH-1:0] ram1_rd_s;

  logic                  in_ready_r;
  logic                  out_valid_r;
  logic [DATA_WIDTH-1:0] out_top_r;
  logic [DATA_WIDTH-1:0] out_mid_r;
  logic [DATA_WIDTH-1:0] out_bot_r;
  logic [ADDR_WIDTH-1:0] out_col_r;
  logic                  out_eol_r;

  assign last_col_s = (col_r == LAST_COL);

`ifdef LINEBUF_PRIME_EN
  // Suppress emission until both line RAMs hold real image lines.
  assign emit_en_s = (row_cnt_r == 2'd2);
`else
  assign emit_en_s = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_RD;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode and per-state strobes (accept in RD, write in WR).
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    w_en_s   = 1'b0;
    case (state_r)
      ST_RD: begin
        if (in_valid) begin
          accept_s = 1'b1;
          state_s  = ST_WR;
        end else begin
          state_s  = ST_RD;
        end
      end
      ST_WR: begin
        w_en_s  = 1'b1;
        state_s = ST_RD;
      end
      default: begin
        state_s = ST_RD;
      end
    endcase
  end

  // ram0 keeps line y-1; ram1 keeps line y-2 (shifted out of ram0 on write).
  linebuf_ram_sp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (LENGTH)
  ) ram0 (
    .clk    (clk),
    .rst    (rst),
    .addr   (col_r),
    .w_en   (w_en_s),
    .w_data (pix_r),
    .r_data (ram0_rd_s)
  );

  linebuf_ram_sp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (LENGTH)
  ) ram1 (
    .clk    (clk),
    .rst    (rst),
    .addr   (col_r),
    .w_en   (w_en_s),
    .w_data (ram0_rd_s),
    .r_data (ram1_rd_s)
  );

  // Pixel capture, column/row tracking and registered column outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_r       <= {DATA_WIDTH{1'b0}};
      col_r       <= {ADDR_WIDTH{1'b0}};
      row_cnt_r   <= 2'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_top_r   <= {DATA_WIDTH{1'b0}};
      out_mid_r   <= {DATA_WIDTH{1'b0}};
      out_bot_r   <= {DATA_WIDTH{1'b0}};
      out_col_r   <= {ADDR_WIDTH{1'b0}};
      out_eol_r   <= 1'b0;
    end else begin
      in_ready_r  <= (state_s == ST_RD);
      out_valid_r <= 1'b0;
      if (accept_s) begin
        pix_r <= in_data;
      end
      if (w_en_s) begin
        out_top_r   <= ram1_rd_s;
        out_mid_r   <= ram0_rd_s;
        out_bot_r   <= pix_r;
        out_col_r   <= col_r;
        out_eol_r   <= last_col_s;
        out_valid_r <= emit_en_s;
        if (last_col_s) begin
          col_r <= {ADDR_WIDTH{1'b0}};
          if (row_cnt_r != 2'd2) begin
            row_cnt_r <= row_cnt_r + 2'd1;
          end
        end else begin
          col_r <= col_r + ADDR_WIDTH'(1);
        end
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_top   = out_top_r;
  assign out_mid   = out_mid_r;
  assign out_bot   = out_bot_r;
  assign out_col   = out_col_r;
  assign out_eol   = out_eol_r;

endmodule

// File: tb/tb_linebuf_3row_ctrl.sv
// Self-checking bench for linebuf_3row_ctrl with LENGTH=8. Expected columns
// come from a history of accepted pixels: the triple for pixel k is
// (hist[k-2L], hist[k-L], hist[k]), with zero for lines not yet seen.
// Honours LINEBUF_PRIME_EN when it is defined for the build.
module tb_linebuf_3row_ctrl;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int L  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic [DW-1:0] out_top;
  logic [DW-1:0] out_mid;
  logic [DW-1:0] out_bot;
  logic [AW-1:0] out_col;
  logic          out_eol;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] hist [$];

  linebuf_3row_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .LENGTH     (L)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_top   (out_top),
    .out_mid   (out_mid),
    .out_bot   (out_bot),
    .out_col   (out_col),
    .out_eol   (out_eol)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one pixel after 'gap' idle cycles; checks handshake and emitted column.
  // Called at a negedge while the controller is in its accepting state.
  task automatic send_pix(input logic [DW-1:0] d, input int gap);
    int            k;
    logic          exp_v;
    logic [DW-1:0] et, em;
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      in_data = DW'($urandom);
      @(negedge clk);
      chk("idle_no_valid", 32'(out_valid), 32'd0);
      chk("idle_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b1;
    in_data  = d;
    chk("ready_accept", 32'(in_ready), 32'd1);
    k  = hist.size();
    et = (k >= 2 * L) ? hist[k - 2 * L] : '0;
    em = (k >= L) ? hist[k - L] : '0;
    hist.push_back(d);
`ifdef LINEBUF_PRIME_EN
    exp_v = (k >= 2 * L);
`else
    exp_v = 1'b1;
`endif
    @(negedge clk);
    chk("ready_busy", 32'(in_ready), 32'd0);
    chk("valid_busy", 32'(out_valid), 32'd0);
    in_data = DW'($urandom);  // in_valid stays high: must not be taken while busy
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(exp_v));
    if (exp_v) begin
      chk("out_top", 32'(out_top), 32'(et));
      chk("out_mid", 32'(out_mid), 32'(em));
      chk("out_bot", 32'(out_bot), 32'(d));
      chk("out_col", 32'(out_col), k % L);
      chk("out_eol", 32'(out_eol), 32'((k % L) == L - 1));
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_top"},   32'(out_top),   32'd0);
    chk({tag, "_mid"},   32'(out_mid),   32'd0);
    chk({tag, "_bot"},   32'(out_bot),   32'd0);
    chk({tag, "_col"},   32'(out_col),   32'd0);
    chk({tag, "_eol"},   32'(out_eol),   32'd0);
    chk({tag, "_ready"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    // Reset, then idle
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_zero_outputs("reset");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle20_valid", 32'(out_valid), 32'd0);
    end

    // Three lines back-to-back, pixel = 16*line + col
    for (int k = 0; k < 3 * L; k++) begin
      send_pix(DW'(16 * (k / L) + (k % L)), 0);
`ifndef LINEBUF_PRIME_EN
      if (k == 0) begin
        chk("first_top", 32'(out_top), 32'h0);
        chk("first_mid", 32'(out_mid), 32'h0);
        chk("first_bot", 32'(out_bot), 32'h0);
      end
`endif
      if (k == 2 * L + 3) begin
        chk("l2c3_top", 32'(out_top), 32'h03);
        chk("l2c3_mid", 32'(out_mid), 32'h13);
        chk("l2c3_bot", 32'(out_bot), 32'h23);
        chk("l2c3_col", 32'(out_col), 32'd3);
      end
      if (k == 2 * L - 1) begin
        chk("wrap_eol", 32'(out_eol), 32'd1);
      end
    end

    // Reset, then same stream with random gaps 0-5
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hist.delete();
    @(negedge clk);
    check_zero_outputs("reset2");
    for (int k = 0; k < 3 * L; k++) begin
      send_pix(DW'(16 * (k / L) + (k % L)), int'($urandom_range(5, 0)));
    end

    // Continue with random pixel values and random gaps
    for (int k = 0; k < 3 * L; k++) begin
      send_pix(DW'($urandom), int'($urandom_range(5, 0)));
    end

    // Reset during WR at line 1, col 4
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hist.delete();
    @(negedge clk);
    for (int k = 0; k < L + 4; k++) begin
      send_pix(DW'(16 * (k / L) + (k % L)), 0);
    end
    in_valid = 1'b1;
    in_data  = DW'(16 + 4);
    @(negedge clk);
    chk("midwr_busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_zero_outputs("midwr_reset");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midwr_no_valid", 32'(out_valid), 32'd0);
    end
    hist.delete();
    for (int k = 0; k < 2 * L + 2; k++) begin
      send_pix(DW'($urandom), int'($urandom_range(2, 0)));
`ifndef LINEBUF_PRIME_EN
      if (k == 0) begin
        chk("post_rst_top", 32'(out_top), 32'h0);
        chk("post_rst_mid", 32'(out_mid), 32'h0);
        chk("post_rst_col", 32'(out_col), 32'd0);
      end
`endif
    end

    in_valid = 1'b0;
    @(negedge clk);
    chk("final_no_valid", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
